// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between pipe_ctrl and the pipeline/divider.
// master = pipeline side, slave = controller side.
interface pipe_ctrl_if;
   logic        stallreq_id_i;
   logic        ex_div_req_i;
   logic        div_ready_i;
   logic        excp_i;
   logic [31:0] excp_vec_i;
   logic        div_start_o;
   logic        div_cancel_o;
   logic [5:0]  stall_o;
   logic        flush_o;
   logic [31:0] new_pc_o;
   logic        div_timeout_o;

   modport master (
      output stallreq_id_i, ex_div_req_i, div_ready_i,
      output excp_i, excp_vec_i,
      input  div_start_o, div_cancel_o, stall_o,
      input  flush_o, new_pc_o, div_timeout_o
   );

   modport slave (
      input  stallreq_id_i, ex_div_req_i, div_ready_i,
      input  excp_i, excp_vec_i,
      output div_start_o, div_cancel_o, stall_o,
      output flush_o, new_pc_o, div_timeout_o
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall arbitration, divider sequencing, flush/redirect.
// Ports: clk, rst (async active-low), bus (pipe_ctrl_if.slave).
module pipe_ctrl #(
   parameter int unsigned DIV_TIMEOUT = 40,
   parameter int unsigned CNT_W       = 6,
   parameter logic [31:0] TRAP_VEC    = 32'h0000_0040
) (
   input  logic       clk,
   input  logic       rst,
   pipe_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      DIV_WAIT,
      DIV_DONE,
      FLUSH
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_TIMEOUT - 1);

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] cnt_q;
   logic             flush_q;
   logic [31:0]      pc_q;

   logic [5:0]       stall;
   logic             start;
   logic             cancel;
   logic             tmo;
   logic [31:0]      cap_vec;
   logic             tmo_hit;

   // Last wait cycle reached with no result: abort the divide.
   assign tmo_hit = (cnt_q == CNT_MAX) && !bus.div_ready_i;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (bus.excp_i)
               state_d = FLUSH;
            else if (bus.ex_div_req_i)
               state_d = DIV_WAIT;
         end
         DIV_WAIT: begin
            if (bus.excp_i || tmo_hit)
               state_d = FLUSH;
            else if (bus.div_ready_i)
               state_d = DIV_DONE;
         end
         DIV_DONE: begin
            state_d = bus.excp_i ? FLUSH : IDLE;
         end
         FLUSH: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      stall   = 6'b000000;
      start   = 1'b0;
      cancel  = 1'b0;
      tmo     = 1'b0;
      cap_vec = bus.excp_vec_i;
      unique case (state_q)
         IDLE: begin
            if (bus.excp_i) begin
               stall = 6'b001111;
            end else if (bus.ex_div_req_i) begin
               stall = 6'b001111;
               start = 1'b1;
            end else if (bus.stallreq_id_i) begin
               stall = 6'b000111;
            end
         end
         DIV_WAIT: begin
            stall = 6'b001111;
            if (bus.excp_i) begin
               cancel = 1'b1;
            end else if (tmo_hit) begin
               cancel  = 1'b1;
               tmo     = 1'b1;
               cap_vec = TRAP_VEC;
            end
         end
         DIV_DONE: begin
            if (bus.excp_i)
               stall = 6'b001111;
         end
         FLUSH: begin
            stall = 6'b000000;
         end
         default: stall = 6'b000000;
      endcase
      // Combinational outputs are forced low while reset is held.
      if (!rst) begin
         stall  = 6'b000000;
         start  = 1'b0;
         cancel = 1'b0;
         tmo    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q   <= '0;
         flush_q <= 1'b0;
         pc_q    <= 32'h0;
      end else begin
         flush_q <= (state_d == FLUSH);
         if (state_d == FLUSH)
            pc_q <= cap_vec;
         if (start)
            cnt_q <= '0;
         else if (state_q == DIV_WAIT && cnt_q != CNT_MAX)
            cnt_q <= cnt_q + 1'b1;
      end
   end

   assign bus.stall_o       = stall;
   assign bus.div_start_o   = start;
   assign bus.div_cancel_o  = cancel;
   assign bus.div_timeout_o = tmo;
   assign bus.flush_o       = flush_q;
   assign bus.new_pc_o      = pc_q;

endmodule
